// File: rtl/gals_ttfs_encoder_pp.sv
`default_nettype none
// ============================================================================
// Module  : gals_ttfs_encoder_pp
// Brief   : Time-to-first-spike encoder. A 4-phase pixel input fills a ping-pong buffer
//           pair, and an AER spike output drains it.
// Revision: 1.0 - initial release
// ============================================================================
module gals_ttfs_encoder_pp #(
    parameter int                PIXEL_VEC_LEN = 16,
    parameter int                NUM_PIXELS    = 20,
    parameter int                DATA_W        = 8,
    parameter int                TIME_W        = 32,
    parameter int                SCALE_W       = 16,
    parameter int                SHIFT_BITS    = 15,
    parameter logic [TIME_W-1:0] T_MAX         = {1'b0, {(TIME_W-1){1'b1}}},
    localparam int               VEC_LEN       = PIXEL_VEC_LEN * NUM_PIXELS,
    localparam int               AW            = $clog2(VEC_LEN),
    localparam int               CW            = $clog2(VEC_LEN + 1)
) (
    input  logic                              local_clk,
    input  logic                              rst_n,
    input  logic                              i_data_req,
    output logic                              o_data_ack,
    input  logic [PIXEL_VEC_LEN*DATA_W-1:0]   i_data_bus,
    input  logic signed [SCALE_W-1:0]         i_cfg_scale,
    input  logic signed [TIME_W-1:0]          i_cfg_offset,
    input  logic                              i_frame_abort,
    output logic                              o_aer_req,
    input  logic                              i_aer_ack,
    output logic [TIME_W-1:0]                 o_aer_time,
    output logic [AW-1:0]                     o_aer_addr,
    output logic                              o_frame_done,
    output logic [CW-1:0]                     o_frame_spikes,
    output logic                              o_busy
);

    localparam int c_PW  = SCALE_W + DATA_W;
    localparam int c_CHW = $clog2(PIXEL_VEC_LEN + 1);
    localparam int c_CIW = (PIXEL_VEC_LEN > 1) ? $clog2(PIXEL_VEC_LEN) : 1;
    localparam int c_PIW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam logic [c_CHW-1:0] c_LAST_CH  = c_CHW'(PIXEL_VEC_LEN);
    localparam logic [c_PIW-1:0] c_LAST_PIX = c_PIW'(NUM_PIXELS - 1);

    typedef enum logic [0:0] {IN_IDLE = 1'b0, IN_ACK = 1'b1} in_state_t;
    typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_SEND = 2'd1, TX_EOF = 2'd2} tx_state_t;

    in_state_t r_in_state, w_in_next;
    tx_state_t r_tx_state, w_tx_next;

    logic [1:0]                r_full;
    logic                      r_last_cap;
    logic                      r_tx_buf;
    logic [c_CHW-1:0]          r_ch;
    logic [c_PIW-1:0]          r_pix;
    logic signed [SCALE_W-1:0] r_scale;
    logic signed [TIME_W-1:0]  r_offset;
    logic [CW-1:0]             r_cnt;
    logic [CW-1:0]             r_frame_spikes;
    logic                      r_aer_req;
    logic [TIME_W-1:0]         r_aer_time;
    logic [AW-1:0]             r_aer_addr;

    logic [TIME_W-1:0]        r_buf_time [2][PIXEL_VEC_LEN];
    logic [PIXEL_VEC_LEN-1:0] r_buf_skip [2];
    logic [c_PIW-1:0]         r_buf_pix  [2];

    logic [TIME_W-1:0]         w_enc_time [PIXEL_VEC_LEN];
    logic [PIXEL_VEC_LEN-1:0]  w_enc_skip;
    logic signed [SCALE_W-1:0] w_scale;
    logic signed [TIME_W-1:0]  w_offset;
    logic w_cap, w_cap_buf, w_xfer, w_step, w_last, w_load, w_start, w_start_buf, w_eof;
    logic              w_cur_skip;
    logic [TIME_W-1:0] w_cur_time;
    logic [AW-1:0]     w_cur_addr;

    // Pixel 0 encodes with the live config; later pixels use the frame's latched copy.
    assign w_scale  = (r_pix == '0) ? i_cfg_scale  : r_scale;
    assign w_offset = (r_pix == '0) ? i_cfg_offset : r_offset;

    for (genvar c = 0; c < PIXEL_VEC_LEN; c++) begin : g_enc
        logic signed [DATA_W-1:0] w_x;
        logic signed [c_PW-1:0]   w_prod;
        logic signed [c_PW-1:0]   w_sh;
        logic signed [TIME_W:0]   w_t;
        assign w_x    = i_data_bus[(c+1)*DATA_W-1 -: DATA_W];
        assign w_prod = w_scale * w_x;
        assign w_sh   = w_prod >>> SHIFT_BITS;
        assign w_t    = {w_offset[TIME_W-1], w_offset}
                      - {{(TIME_W+1-c_PW){w_sh[c_PW-1]}}, w_sh};
        assign w_enc_skip[c] = !w_t[TIME_W] && (w_t[TIME_W-1:0] >= T_MAX);
        assign w_enc_time[c] = w_t[TIME_W] ? '0 : w_t[TIME_W-1:0];
    end

    assign w_cap       = (r_in_state == IN_IDLE) && i_data_req && !(&r_full) && !i_frame_abort;
    assign w_cap_buf   = r_full[0];
    assign w_xfer      = r_aer_req && i_aer_ack;
    assign w_step      = (r_tx_state == TX_SEND) && (!r_aer_req || i_aer_ack);
    assign w_last      = w_step && (r_ch == c_LAST_CH);
    assign w_load      = w_step && (r_ch != c_LAST_CH);
    assign w_start     = (r_tx_state == TX_IDLE) && (|r_full);
    // With both buffers full, the older one is the one not written most recently.
    assign w_start_buf = (&r_full) ? ~r_last_cap : r_full[1];
    assign w_eof       = (r_buf_pix[r_tx_buf] == c_LAST_PIX);
    assign w_cur_skip  = r_buf_skip[r_tx_buf][r_ch[c_CIW-1:0]];
    assign w_cur_time  = r_buf_time[r_tx_buf][r_ch[c_CIW-1:0]];
    assign w_cur_addr  = AW'(int'(r_buf_pix[r_tx_buf]) * PIXEL_VEC_LEN + int'(r_ch));

    always_comb begin
        w_in_next = r_in_state;
        case (r_in_state)
            IN_IDLE: if (w_cap) w_in_next = IN_ACK;
            IN_ACK:  if (!i_data_req) w_in_next = IN_IDLE;
            default: w_in_next = IN_IDLE;
        endcase
        if (i_frame_abort) w_in_next = IN_IDLE;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            TX_IDLE: if (w_start) w_tx_next = TX_SEND;
            TX_SEND: if (w_last) w_tx_next = w_eof ? TX_EOF : TX_IDLE;
            TX_EOF:  w_tx_next = TX_IDLE;
            default: w_tx_next = TX_IDLE;
        endcase
        if (i_frame_abort) w_tx_next = TX_IDLE;
    end

    always_ff @(posedge local_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_state <= IN_IDLE;
            r_tx_state <= TX_IDLE;
        end else begin
            r_in_state <= w_in_next;
            r_tx_state <= w_tx_next;
        end
    end

    always_ff @(posedge local_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full         <= '0;
            r_last_cap     <= 1'b0;
            r_tx_buf       <= 1'b0;
            r_ch           <= '0;
            r_pix          <= '0;
            r_scale        <= '0;
            r_offset       <= '0;
            r_cnt          <= '0;
            r_frame_spikes <= '0;
            r_aer_req      <= 1'b0;
            r_aer_time     <= '0;
            r_aer_addr     <= '0;
        end else if (i_frame_abort) begin
            r_full     <= '0;
            r_ch       <= '0;
            r_pix      <= '0;
            r_cnt      <= '0;
            r_aer_req  <= 1'b0;
            r_aer_time <= '0;
            r_aer_addr <= '0;
        end else begin
            if (w_cap) begin
                r_full[w_cap_buf] <= 1'b1;
                r_last_cap        <= w_cap_buf;
                r_pix             <= (r_pix == c_LAST_PIX) ? '0 : r_pix + c_PIW'(1);
                if (r_pix == '0) begin
                    r_scale  <= i_cfg_scale;
                    r_offset <= i_cfg_offset;
                end
            end
            // Capture only targets an empty buffer, so it never collides with this free.
            if (w_last) r_full[r_tx_buf] <= 1'b0;
            if (w_start) begin
                r_tx_buf <= w_start_buf;
                r_ch     <= '0;
            end
            if (w_load) r_ch <= r_ch + c_CHW'(1);
            if (w_load && !w_cur_skip) begin
                r_aer_req  <= 1'b1;
                r_aer_time <= w_cur_time;
                r_aer_addr <= w_cur_addr;
            end else if (w_step) begin
                r_aer_req  <= 1'b0;
                r_aer_time <= '0;
                r_aer_addr <= '0;
            end
            if (w_last && w_eof) begin
                r_frame_spikes <= r_cnt + CW'(w_xfer);
                r_cnt          <= '0;
            end else if (w_xfer) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge local_clk) begin
        if (w_cap) begin
            r_buf_time[w_cap_buf] <= w_enc_time;
            r_buf_skip[w_cap_buf] <= w_enc_skip;
            r_buf_pix[w_cap_buf]  <= r_pix;
        end
    end

    assign o_data_ack     = (r_in_state == IN_ACK);
    assign o_aer_req      = r_aer_req;
    assign o_aer_time     = r_aer_time;
    assign o_aer_addr     = r_aer_addr;
    assign o_frame_done   = (r_tx_state == TX_EOF);
    assign o_frame_spikes = r_frame_spikes;
    assign o_busy         = (r_in_state != IN_IDLE) || (r_tx_state != TX_IDLE) || (|r_full);

endmodule
`default_nettype wire

// File: tb/tb_gals_ttfs_encoder_pp.sv
`default_nettype none
// ============================================================================
// Module  : tb_gals_ttfs_encoder_pp
// Brief   : Directed vector table plus hand-written sequences for gals_ttfs_encoder_pp.
// Revision: 1.0 - initial release
// ============================================================================
module tb_gals_ttfs_encoder_pp;

    logic          local_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_data_req = 1'b0;
    logic          o_data_ack;
    logic [127:0]  i_data_bus = '0;
    logic [15:0]   i_cfg_scale = '0;
    logic [31:0]   i_cfg_offset = '0;
    logic          i_frame_abort = 1'b0;
    logic          o_aer_req;
    logic          i_aer_ack = 1'b0;
    logic [31:0]   o_aer_time;
    logic [8:0]    o_aer_addr;
    logic          o_frame_done;
    logic [8:0]    o_frame_spikes;
    logic          o_busy;

    gals_ttfs_encoder_pp dut (
        .local_clk      (local_clk),
        .rst_n          (rst_n),
        .i_data_req     (i_data_req),
        .o_data_ack     (o_data_ack),
        .i_data_bus     (i_data_bus),
        .i_cfg_scale    (i_cfg_scale),
        .i_cfg_offset   (i_cfg_offset),
        .i_frame_abort  (i_frame_abort),
        .o_aer_req      (o_aer_req),
        .i_aer_ack      (i_aer_ack),
        .o_aer_time     (o_aer_time),
        .o_aer_addr     (o_aer_addr),
        .o_frame_done   (o_frame_done),
        .o_frame_spikes (o_frame_spikes),
        .o_busy         (o_busy)
    );

    always #5 local_clk = ~local_clk;

    typedef struct {
        logic [15:0] scale;
        logic [31:0] offset;
        logic [7:0]  x;
        int          n;
        logic [31:0] t;
    } vec_t;

    typedef struct {
        logic [8:0]  addr;
        logic [31:0] t;
    } spk_t;

    vec_t vecs [13];
    spk_t q [$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   cyc_cap = 0;
    int   done_cnt = 0;
    int   last_spikes = 0;

    always @(posedge local_clk) cyc <= cyc + 1;

    always @(negedge local_clk) begin
        if (rst_n) begin
            if (o_aer_req && i_aer_ack) q.push_back('{addr: o_aer_addr, t: o_aer_time});
            if (o_frame_done) begin
                done_cnt    <= done_cnt + 1;
                last_spikes <= int'(o_frame_spikes);
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge local_clk);
        #1;
    endtask

    task automatic wait_ack_low(input int limit);
        int n = 0;
        while (o_data_ack && n < limit) begin tick(); n++; end
        if (o_data_ack) check("ack_release_timeout", 1, 0);
    endtask

    task automatic capture(input logic [127:0] bus, input int limit, output bit ok);
        int n = 0;
        ok = 1'b0;
        i_data_bus = bus;
        i_data_req = 1'b1;
        while (!ok && n < limit) begin
            tick();
            n++;
            if (o_data_ack) ok = 1'b1;
        end
        cyc_cap = cyc;
        i_data_req = 1'b0;
        if (!ok) check("capture_ack_timeout", 0, 1);
        wait_ack_low(20);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (o_busy && n < limit) begin tick(); n++; end
        if (o_busy) check("idle_timeout", 1, 0);
    endtask

    task automatic do_abort();
        i_frame_abort = 1'b1;
        tick();
        i_frame_abort = 1'b0;
    endtask

    task automatic check_spikes(input string tag, input int base, input int exp_n,
                                input int addr0, input logic [31:0] exp_t);
        int errs = 0;
        check({tag, "_count"}, q.size() - base, exp_n);
        for (int i = base; i < q.size(); i++)
            if (int'(q[i].addr) != addr0 + (i - base) || q[i].t != exp_t) errs++;
        check({tag, "_content_errors"}, errs, 0);
    endtask

    function automatic longint q_addr(input int idx);
        return (idx < q.size()) ? longint'(q[idx].addr) : -1;
    endfunction

    function automatic longint q_time(input int idx);
        return (idx < q.size()) ? longint'(q[idx].t) : -1;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        bit          ok;
        bit          seen;
        int          base;
        int          c0;
        int          n;
        int          done0;
        logic [127:0] bus;

        vecs[0]  = '{16'h0160, 32'd1,          8'h80, 16, 32'd3};
        vecs[1]  = '{16'h0160, 32'd1,          8'h00, 16, 32'd1};
        vecs[2]  = '{16'h0160, 32'd1,          8'h7F, 16, 32'd0};
        vecs[3]  = '{16'h0160, 32'd0,          8'h7F, 16, 32'd0};
        vecs[4]  = '{16'h0000, 32'h7FFF_FFFF,  8'h00,  0, 32'd0};
        vecs[5]  = '{16'h0160, 32'h7FFF_FFFF,  8'h7F, 16, 32'h7FFF_FFFE};
        vecs[6]  = '{16'h0160, 32'h7FFF_FFFF,  8'h80,  0, 32'd0};
        vecs[7]  = '{16'h7FFF, 32'd1000,       8'h64, 16, 32'd901};
        vecs[8]  = '{16'h8000, 32'd0,          8'h7F, 16, 32'd127};
        vecs[9]  = '{16'h8000, 32'd0,          8'h80, 16, 32'd0};
        vecs[10] = '{16'h4000, 32'd10,         8'hFD, 16, 32'd12};
        vecs[11] = '{16'hFFFF, 32'd7,          8'h01, 16, 32'd8};
        vecs[12] = '{16'h0000, 32'hFFFF_FFF6,  8'h00, 16, 32'd0};

        // Reset state
        repeat (3) tick();
        check("rst_data_ack", o_data_ack, 0);
        check("rst_aer_req", o_aer_req, 0);
        check("rst_aer_time", o_aer_time, 0);
        check("rst_aer_addr", o_aer_addr, 0);
        check("rst_frame_done", o_frame_done, 0);
        check("rst_frame_spikes", o_frame_spikes, 0);
        check("rst_busy", o_busy, 0);
        rst_n = 1'b1;
        i_aer_ack = 1'b1;
        tick();

        // Encoding table: each vector is pixel 0 of a fresh frame, all channels equal
        for (int i = 0; i < 13; i++) begin
            do_abort();
            i_cfg_scale  = vecs[i].scale;
            i_cfg_offset = vecs[i].offset;
            base = q.size();
            capture({16{vecs[i].x}}, 20, ok);
            c0 = cyc_cap;
            wait_idle(200);
            check($sformatf("v%0d_cycles", i), cyc - c0, 18);
            check_spikes($sformatf("v%0d", i), base, vecs[i].n, 0, vecs[i].t);
        end

        // Mixed samples on channels 0..2 of pixel 0
        do_abort();
        i_cfg_scale = 16'h0160;
        i_cfg_offset = 32'd1;
        base = q.size();
        capture({104'd0, 8'h7F, 8'h00, 8'h80}, 20, ok);
        wait_idle(200);
        check("mix_count", q.size() - base, 16);
        check("mix_addr0", q_addr(base), 0);
        check("mix_time0", q_time(base), 3);
        check("mix_addr1", q_addr(base + 1), 1);
        check("mix_time1", q_time(base + 1), 1);
        check("mix_addr2", q_addr(base + 2), 2);
        check("mix_time2", q_time(base + 2), 0);

        // Mid-frame config change must not affect pixel 1
        i_cfg_scale = 16'h0000;
        i_cfg_offset = 32'd500;
        base = q.size();
        capture({16{8'h80}}, 20, ok);
        wait_idle(200);
        check_spikes("latch", base, 16, 16, 32'd3);

        // Ping-pong with the spike output stalled on pixel 0
        do_abort();
        i_aer_ack = 1'b0;
        i_cfg_scale = 16'h0160;
        i_cfg_offset = 32'd1;
        base = q.size();
        capture('0, 20, ok);
        capture('0, 20, ok);
        check("pp_pix1_acked", ok, 1);
        i_data_bus = '0;
        i_data_req = 1'b1;
        seen = 1'b0;
        repeat (30) begin tick(); if (o_data_ack) seen = 1'b1; end
        check("pp_backpressure_ack", seen, 0);
        check("pp_hold_req", o_aer_req, 1);
        check("pp_hold_addr", o_aer_addr, 0);
        i_aer_ack = 1'b1;
        n = 0;
        while (!o_data_ack && n < 100) begin tick(); n++; end
        check("pp_pix2_acked", o_data_ack, 1);
        i_data_req = 1'b0;
        wait_ack_low(20);
        wait_idle(300);
        check_spikes("pp", base, 48, 0, 32'd1);

        // Full frame of 20 pixels
        do_abort();
        i_cfg_scale = 16'h0160;
        i_cfg_offset = 32'd100;
        base = q.size();
        done0 = done_cnt;
        for (int c = 0; c < 16; c++) bus[c*8 +: 8] = 8'(c);
        for (int p = 0; p < 20; p++) capture(bus, 200, ok);
        wait_idle(1000);
        tick();
        check_spikes("frame", base, 320, 0, 32'd100);
        check("frame_done_pulses", done_cnt - done0, 1);
        check("frame_spikes_at_done", last_spikes, 320);
        check("frame_spikes_held", o_frame_spikes, 320);
        i_cfg_offset = 32'd1;
        base = q.size();
        capture('0, 20, ok);
        wait_idle(200);
        check_spikes("wrap", base, 16, 0, 32'd1);

        // Abort at pixel 5 channel 7 with a spike pending
        do_abort();
        for (int p = 0; p < 5; p++) capture('0, 100, ok);
        wait_idle(300);
        i_aer_ack = 1'b0;
        capture('0, 20, ok);
        i_aer_ack = 1'b1;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 100) begin
            tick();
            n++;
            if (o_aer_req && o_aer_addr == 9'd87) seen = 1'b1;
        end
        i_aer_ack = 1'b0;
        check("abort_reached_addr87", seen, 1);
        done0 = done_cnt;
        base = q.size();
        do_abort();
        check("abort_aer_req", o_aer_req, 0);
        check("abort_busy", o_busy, 0);
        check("abort_data_ack", o_data_ack, 0);
        repeat (30) tick();
        check("abort_no_done", done_cnt - done0, 0);
        check("abort_no_spikes", q.size() - base, 0);
        i_aer_ack = 1'b1;
        capture('0, 20, ok);
        wait_idle(200);
        check_spikes("post_abort", base, 16, 0, 32'd1);

        // Asynchronous reset in the middle of a pending transfer
        i_aer_ack = 1'b0;
        capture('0, 20, ok);
        n = 0;
        while (!o_aer_req && n < 50) begin tick(); n++; end
        check("areset_req_pending", o_aer_req, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("areset_aer_req", o_aer_req, 0);
        check("areset_aer_time", o_aer_time, 0);
        check("areset_aer_addr", o_aer_addr, 0);
        check("areset_busy", o_busy, 0);
        check("areset_data_ack", o_data_ack, 0);
        check("areset_frame_spikes", o_frame_spikes, 0);
        tick();
        rst_n = 1'b1;
        i_aer_ack = 1'b1;
        i_cfg_offset = 32'd1;
        base = q.size();
        capture('0, 20, ok);
        wait_idle(200);
        check_spikes("post_reset", base, 16, 0, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
